ftdi_tx_arbiter: RTL and testbench

FTDI_TX_ARBITER -- requirements
Module: ftdi_tx_arbiter

---
 rtl/ftdi_tx_arbiter.sv | 169 ++++++++++++++++
 tb/tb_ftdi_tx_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ftdi_tx_arbiter.sv
// Round-robin packetiser feeding the Tx FIFO of the FTDI FIFO bridge.
// Each granted requester gets one framed packet: sync byte, requester id,
// payload length, payload bytes, then an XOR checksum of the payload.
module ftdi_tx_arbiter #(
    parameter int         pNumReq   = 4,
    parameter logic [7:0] pSyncByte = 8'hA5
) (
    input  logic                   iClk,
    input  logic                   iRst_n,
    input  logic [pNumReq-1:0]     iReq,
    input  logic [8*pNumReq-1:0]   iReqLen,
    input  logic [8*pNumReq-1:0]   iReqData,
    input  logic [pNumReq-1:0]     iReqValid,
    output logic [pNumReq-1:0]     oReqAck,
    output logic [pNumReq-1:0]     oGrant,
    output logic                   oTxEn,
    output logic [7:0]             oTxData,
    input  logic                   iTxFull,
    output logic                   oBusy,
    output logic                   oPktDone
);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        ID,
        LEN,
        PAYLOAD,
        CSUM
    } state_t;

    state_t               state_q, state_d;
    logic [pNumReq-1:0]   grant_q, grant_d;
    logic [2:0]           idx_q, idx_d;
    logic [2:0]           ptr_q, ptr_d;
    logic [7:0]           count_q, count_d;
    logic [7:0]           csum_q, csum_d;

    logic [pNumReq-1:0]   reqRot;
    logic                 selFound;
    logic [2:0]           selIdx;
    logic [7:0]           selLen;
    logic [7:0]           grantData;
    logic                 grantValid;

    // Round-robin search: rotate the requests so the pointer lane is bit 0,
    // take the lowest set bit and map it back to an absolute index.
    always_comb begin
        reqRot   = pNumReq'({iReq, iReq} >> ptr_q);
        selFound = 1'b0;
        selIdx   = '0;
        for (int j = 0; j < pNumReq; j++) begin
            if (!selFound && reqRot[j]) begin
                selFound = 1'b1;
                selIdx   = 3'((int'(ptr_q) + j) % pNumReq);
            end
        end
    end

    // Lane multiplexers: length of the candidate lane, payload of the owner.
    always_comb begin
        selLen     = '0;
        grantData  = '0;
        grantValid = 1'b0;
        for (int k = 0; k < pNumReq; k++) begin
            if (selIdx == 3'(k)) begin
                selLen = iReqLen[8*k +: 8];
            end
            if (idx_q == 3'(k)) begin
                grantData  = iReqData[8*k +: 8];
                grantValid = iReqValid[k];
            end
        end
    end

    // Packet framing FSM: next state, datapath updates and FIFO-side outputs.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        idx_d    = idx_q;
        ptr_d    = ptr_q;
        count_d  = count_q;
        csum_d   = csum_q;
        oTxEn    = 1'b0;
        oTxData  = 8'h00;
        oReqAck  = '0;
        oPktDone = 1'b0;
        case (state_q)
            IDLE: begin
                if (selFound) begin
                    grant_d = pNumReq'(1) << selIdx;
                    idx_d   = selIdx;
                    count_d = selLen;
                    csum_d  = 8'h00;
                    state_d = SYNC;
                end
            end
            SYNC: begin
                if (!iTxFull) begin
                    oTxEn   = 1'b1;
                    oTxData = pSyncByte;
                    state_d = ID;
                end
            end
            ID: begin
                if (!iTxFull) begin
                    oTxEn   = 1'b1;
                    oTxData = {5'b0, idx_q};
                    state_d = LEN;
                end
            end
            LEN: begin
                if (!iTxFull) begin
                    oTxEn   = 1'b1;
                    oTxData = count_q;
                    state_d = (count_q == 8'd0) ? CSUM : PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (grantValid && !iTxFull) begin
                    oTxEn   = 1'b1;
                    oTxData = grantData;
                    oReqAck = pNumReq'(1) << idx_q;
                    csum_d  = csum_q ^ grantData;
                    count_d = count_q - 8'd1;
                    if (count_q == 8'd1) begin
                        state_d = CSUM;
                    end
                end
            end
            CSUM: begin
                if (!iTxFull) begin
                    oTxEn    = 1'b1;
                    oTxData  = csum_q;
                    oPktDone = 1'b1;
                    grant_d  = '0;
                    ptr_d    = (idx_q == 3'(pNumReq - 1)) ? 3'd0 : idx_q + 3'd1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign oGrant = grant_q;
    assign oBusy  = (state_q != IDLE);

    // State and datapath registers; reset abandons any packet in flight.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            count_q <= '0;
            csum_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            csum_q  <= csum_d;
        end
    end

endmodule

// File: tb/tb_ftdi_tx_arbiter.sv
// Bench for ftdi_tx_arbiter: a table of packet requests is played in order;
// every expected FIFO byte is queued when a packet is requested and popped
// as the DUT writes it.
module tb_ftdi_tx_arbiter;

    localparam int N = 4;

    logic             iClk = 1'b0;
    logic             iRst_n;
    logic [N-1:0]     iReq;
    logic [8*N-1:0]   iReqLen;
    logic [8*N-1:0]   iReqData;
    logic [N-1:0]     iReqValid;
    logic [N-1:0]     oReqAck;
    logic [N-1:0]     oGrant;
    logic             oTxEn;
    logic [7:0]       oTxData;
    logic             iTxFull;
    logic             oBusy;
    logic             oPktDone;

    ftdi_tx_arbiter #(.pNumReq(N), .pSyncByte(8'hA5)) dut (
        .iClk      (iClk),
        .iRst_n    (iRst_n),
        .iReq      (iReq),
        .iReqLen   (iReqLen),
        .iReqData  (iReqData),
        .iReqValid (iReqValid),
        .oReqAck   (oReqAck),
        .oGrant    (oGrant),
        .oTxEn     (oTxEn),
        .oTxData   (oTxData),
        .iTxFull   (iTxFull),
        .oBusy     (oBusy),
        .oPktDone  (oPktDone)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic [3:0] req;
        logic [7:0] len;
        logic [7:0] base;
        logic [7:0] step;
        bit         toggle;
        int         stallAt;
        int         resetAt;
        bit         hold;
        int         expIdx;
    } vec_t;

    vec_t       vecs[14];
    logic [7:0] expQ[$];
    int         checks = 0;
    int         errors = 0;
    int         curIdx = 0;
    int         payloadPos = 0;
    int         ackCount = 0;
    int         bytesWritten = 0;
    int         stallLeft = 0;
    bit         stallUsed = 1'b0;
    bit         doneSeen = 1'b0;
    logic [7:0] expByte;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: compare every FIFO write against the scoreboard queue.
    always @(negedge iClk) begin
        if (oTxEn) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedWrite actual=%0h expected=none", oTxData);
            end else begin
                expByte = expQ.pop_front();
                checkOutput("txData", 32'(oTxData), 32'(expByte));
            end
            bytesWritten++;
        end else begin
            checkOutput("txDataIdle", 32'(oTxData), 32'h0);
        end
        if (iTxFull) begin
            checkOutput("txEnWhileFull", 32'(oTxEn), 32'h0);
        end
        if (oReqAck != '0) begin
            checkOutput("ackLane", 32'(oReqAck), 32'(1 << curIdx));
            checkOutput("ackWithTxEn", 32'(oTxEn), 32'h1);
            ackCount++;
            payloadPos++;
        end
        if (oPktDone) begin
            checkOutput("doneWithLastByte", 32'({oTxEn, expQ.size() == 0}), 32'h3);
            doneSeen = 1'b1;
        end
    end

    // Drive one cycle of requester/FIFO inputs for the packet in flight.
    task automatic applyStimulus(input vec_t r, input int cyc);
        logic       v;
        logic [7:0] b;
        if (stallLeft > 0) begin
            iTxFull = 1'b1;
            stallLeft--;
        end else if (!stallUsed && bytesWritten == r.stallAt) begin
            iTxFull   = 1'b1;
            stallUsed = 1'b1;
            stallLeft = 4;
        end else begin
            iTxFull = 1'b0;
        end
        v = r.toggle ? cyc[0] : 1'b1;
        b = r.base + 8'(payloadPos) * r.step;
        for (int k = 0; k < N; k++) begin
            iReqValid[k]       = (k == r.expIdx) ? v : ~v;
            iReqData[8*k +: 8] = (k == r.expIdx) ? b : (b ^ 8'hC3);
            iReqLen[8*k +: 8]  = (k == r.expIdx) ? r.len : (r.len + 8'(k + 1));
        end
    endtask

    // Play one packet: queue its bytes, request it, run it to completion or reset.
    task automatic runPacket(input vec_t r);
        logic [7:0] b;
        logic [7:0] sum;
        int         cyc;
        curIdx       = r.expIdx;
        payloadPos   = 0;
        ackCount     = 0;
        bytesWritten = 0;
        stallLeft    = 0;
        stallUsed    = 1'b0;
        doneSeen     = 1'b0;
        sum          = 8'h00;
        expQ.push_back(8'hA5);
        expQ.push_back(8'(r.expIdx));
        expQ.push_back(r.len);
        for (int i = 0; i < int'(r.len); i++) begin
            b = r.base + 8'(i) * r.step;
            sum = sum ^ b;
            expQ.push_back(b);
        end
        expQ.push_back(sum);

        iReq = r.req;
        applyStimulus(r, 0);
        checkOutput("idleBeforeGrant", 32'({oBusy, oGrant}), 32'h0);
        @(posedge iClk);
        #1;
        checkOutput("grant", 32'(oGrant), 32'(1 << r.expIdx));
        checkOutput("busy", 32'(oBusy), 32'h1);
        if (!r.hold) begin
            iReq = '0;
        end

        cyc = 1;
        while (!doneSeen && cyc < 200) begin
            if (payloadPos == r.resetAt) begin
                iRst_n = 1'b0;
                #1;
                checkOutput("resetOutputs",
                            32'({oTxEn, oTxData, oReqAck, oGrant, oBusy, oPktDone}), 32'h0);
                checkOutput("abandonedBytes", 32'(expQ.size()), 32'(int'(r.len) - r.resetAt + 1));
                expQ.delete();
                iReq      = '0;
                iReqValid = '0;
                iTxFull   = 1'b0;
                repeat (2) @(posedge iClk);
                @(negedge iClk);
                iRst_n = 1'b1;
                @(posedge iClk);
                #1;
                checkOutput("idleAfterReset", 32'({oBusy, oGrant}), 32'h0);
                return;
            end
            applyStimulus(r, cyc);
            @(posedge iClk);
            #1;
            cyc++;
        end

        if (!doneSeen) begin
            checks++;
            errors++;
            $display("[TB] FAIL packetTimeout actual=%0d cycles expected=done", cyc);
        end
        if (r.stallAt < 0 && !r.toggle) begin
            checkOutput("packetCycles", 32'(cyc), 32'(int'(r.len) + 5));
        end
        checkOutput("ackCount", 32'(ackCount), 32'(r.len));
        checkOutput("queueEmpty", 32'(expQ.size()), 32'h0);
        checkOutput("idleAfterPkt", 32'({oBusy, oGrant}), 32'h0);
    endtask

    initial begin
        //            req      len    base   step  tog stall rst hold idx
        vecs[0]  = '{4'b0100, 8'd3, 8'h11, 8'h11, 0, -1, -1, 0, 2};
        vecs[1]  = '{4'b0011, 8'd2, 8'h40, 8'h03, 0, -1, -1, 0, 0};
        vecs[2]  = '{4'b0011, 8'd0, 8'h00, 8'h00, 0, -1, -1, 0, 1};
        vecs[3]  = '{4'b1000, 8'd4, 8'h5A, 8'h21, 1, -1, -1, 0, 3};
        vecs[4]  = '{4'b0001, 8'd3, 8'h10, 8'h01, 0,  2, -1, 0, 0};
        vecs[5]  = '{4'b0001, 8'd3, 8'h80, 8'h07, 0,  3, -1, 0, 0};
        vecs[6]  = '{4'b0100, 8'd5, 8'h30, 8'h01, 0, -1,  2, 0, 2};
        vecs[7]  = '{4'b0011, 8'd2, 8'h77, 8'h11, 0, -1, -1, 0, 0};
        vecs[8]  = '{4'b1000, 8'd1, 8'h9C, 8'h00, 0, -1, -1, 0, 3};
        vecs[9]  = '{4'b1111, 8'd1, 8'hE1, 8'h00, 0, -1, -1, 1, 0};
        vecs[10] = '{4'b1111, 8'd1, 8'hE2, 8'h00, 0, -1, -1, 1, 1};
        vecs[11] = '{4'b1111, 8'd1, 8'hE3, 8'h00, 0, -1, -1, 1, 2};
        vecs[12] = '{4'b1111, 8'd1, 8'hE4, 8'h00, 0, -1, -1, 1, 3};
        vecs[13] = '{4'b1111, 8'd1, 8'hE5, 8'h00, 0, -1, -1, 1, 0};

        iRst_n    = 1'b0;
        iReq      = '0;
        iReqLen   = '0;
        iReqData  = '0;
        iReqValid = '0;
        iTxFull   = 1'b0;
        #2;
        checkOutput("resetState",
                    32'({oTxEn, oTxData, oReqAck, oGrant, oBusy, oPktDone}), 32'h0);
        repeat (2) @(posedge iClk);
        @(negedge iClk);
        iRst_n = 1'b1;
        @(posedge iClk);
        #1;

        for (int v = 0; v < 14; v++) begin
            runPacket(vecs[v]);
        end

        iReq = '0;
        repeat (3) @(posedge iClk);
        #1;
        checkOutput("finalIdle", 32'({oBusy, oGrant, oTxEn}), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
